// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N producers.
// Each grant lasts up to MAX_BURST words; no write is issued while the FIFO is full.
module fifo_wr_arbiter #(
    parameter int unsigned N         = 4,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                   w_clk,
    input  logic                   rst_w_n,
    input  logic [N-1:0]           req,
    input  logic [N*WIDTH-1:0]     req_data,
    output logic [N-1:0]           ack,
    input  logic                   full,
    output logic                   w_en,
    output logic [WIDTH-1:0]       w_data,
    output logic                   busy,
    output logic [$clog2(N)-1:0]   owner_id,
    output logic [7:0]             burst_cnt,
    output logic [CNT_W-1:0]       wr_count
);

    localparam int unsigned IdW = $clog2(N);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e           state_q, state_d;
    logic [IdW-1:0]   owner_q, owner_d;
    logic [IdW-1:0]   last_owner_q, last_owner_d;
    logic [7:0]       burst_q, burst_d;
    logic [CNT_W-1:0] wr_count_q, wr_count_d;

    logic             accept;
    logic             release_grant;
    logic             found;
    logic [IdW-1:0]   pick;
    logic [IdW-1:0]   idx;

    always_ff @(posedge w_clk) begin
        if (!rst_w_n) begin
            state_q      <= StIdle;
            owner_q      <= '0;
            last_owner_q <= IdW'(N - 1);
            burst_q      <= '0;
            wr_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            burst_q      <= burst_d;
            wr_count_q   <= wr_count_d;
        end
    end

    // First requester strictly after last_owner, wrapping modulo N.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = IdW'((32'(last_owner_q) + k) % N);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        burst_d      = burst_q;
        wr_count_d   = wr_count_q;
        case (state_q)
            StIdle: begin
                if (found) begin
                    owner_d = pick;
                    burst_d = '0;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                if (accept) begin
                    burst_d    = burst_q + 8'd1;
                    wr_count_d = wr_count_q + CNT_W'(1);
                end
                if (release_grant) begin
                    state_d      = StIdle;
                    last_owner_d = owner_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy          = (state_q == StGrant);
        accept        = busy && req[owner_q] && !full;
        release_grant = busy && ((accept && (burst_q == 8'(MAX_BURST - 1))) || !req[owner_q]);
        ack           = '0;
        w_data        = '0;
        w_en          = accept;
        if (accept) begin
            ack[owner_q] = 1'b1;
            w_data       = req_data[owner_q*WIDTH +: WIDTH];
        end
    end

    assign owner_id  = owner_q;
    assign burst_cnt = burst_q;
    assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: producer queues drive req, a negedge monitor
// pops expected (owner, data) pairs whenever the DUT writes.
module tb_fifo_wr_arbiter;

    localparam int unsigned N   = 4;
    localparam int unsigned W   = 8;
    localparam int unsigned IDW = 2;

    logic             w_clk;
    logic             rst_w_n;
    logic [N-1:0]     req;
    logic [N*W-1:0]   req_data;
    logic             full;
    logic [N-1:0]     ack;
    logic             w_en;
    logic [W-1:0]     w_data;
    logic             busy;
    logic [IDW-1:0]   owner_id;
    logic [7:0]       burst_cnt;
    logic [15:0]      wr_count;

    logic [N-1:0]     ack_w;
    logic             w_en_w;
    logic [W-1:0]     w_data_w;
    logic             busy_w;
    logic [IDW-1:0]   owner_id_w;
    logic [7:0]       burst_cnt_w;
    logic [3:0]       wr_count_w;

    fifo_wr_arbiter #(.N(4), .WIDTH(8), .MAX_BURST(4), .CNT_W(16)) dut (
        .w_clk(w_clk), .rst_w_n(rst_w_n), .req(req), .req_data(req_data), .ack(ack),
        .full(full), .w_en(w_en), .w_data(w_data), .busy(busy), .owner_id(owner_id),
        .burst_cnt(burst_cnt), .wr_count(wr_count)
    );

    // Narrow-counter instance sharing the same stimulus, used for wrap checks.
    fifo_wr_arbiter #(.N(4), .WIDTH(8), .MAX_BURST(4), .CNT_W(4)) dut_w (
        .w_clk(w_clk), .rst_w_n(rst_w_n), .req(req), .req_data(req_data), .ack(ack_w),
        .full(full), .w_en(w_en_w), .w_data(w_data_w), .busy(busy_w), .owner_id(owner_id_w),
        .burst_cnt(burst_cnt_w), .wr_count(wr_count_w)
    );

    int tests = 0;
    int fails = 0;

    logic [W-1:0]     pq [N][$];
    logic [IDW+W-1:0] exp_q [$];
    logic [N-1:0]     ack_seen = '0;
    logic             wen_seen = 1'b0;
    logic             counting = 1'b0;
    int               busy_cnt = 0;
    int               idle_cnt = 0;
    logic             fifo_on  = 1'b0;
    int               occ      = 0;

    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic push_exp(input int owner, input int data);
        exp_q.push_back({IDW'(owner), W'(data)});
    endtask

    function automatic logic pending();
        logic p = 1'b0;
        for (int i = 0; i < N; i++) if (pq[i].size() != 0) p = 1'b1;
        return p;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req[i] = (pq[i].size() != 0);
            req_data[i*W +: W] = (pq[i].size() != 0) ? pq[i][0] : '0;
        end
    endtask

    // Advance one cycle: retire words acked at the last edge, update FIFO model, re-drive.
    task automatic tick();
        @(posedge w_clk);
        #1;
        for (int i = 0; i < N; i++) if (ack_seen[i] && pq[i].size() != 0) void'(pq[i].pop_front());
        if (fifo_on) begin
            occ  = occ + (wen_seen ? 1 : 0);
            full = (occ >= 16);
        end
        drive();
        #1;
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while ((pending() || exp_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        check({name, "_drained"}, 32'(pending() || exp_q.size() != 0), 32'd0);
    endtask

    task automatic wait_exp(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check({name, "_written"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst_w_n = 1'b0;
        full    = 1'b0;
        fifo_on = 1'b0;
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_wen", 32'(w_en), 32'd0);
        check("rst_wdata", 32'(w_data), 32'd0);
        check("rst_owner", 32'(owner_id), 32'd0);
        check("rst_burst", 32'(burst_cnt), 32'd0);
        check("rst_wrcount", 32'(wr_count), 32'd0);
        check("rst_wrcount_w", 32'(wr_count_w), 32'd0);
        rst_w_n = 1'b1;
    endtask

    // Monitor: compare every DUT write against the scoreboard head.
    initial begin
        logic [IDW+W-1:0] e;
        logic [N-1:0]     oh;
        forever begin
            @(negedge w_clk);
            ack_seen = ack;
            wen_seen = w_en;
            if (counting) begin
                if (busy) busy_cnt++;
                else idle_cnt++;
            end
            if (w_en) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: got data 0x%0h owner %0d, expected no write at %0t",
                             w_data, owner_id, $time);
                end else begin
                    e  = exp_q.pop_front();
                    oh = '0;
                    oh[e[IDW+W-1:W]] = 1'b1;
                    check("write_data", 32'(w_data), 32'(e[W-1:0]));
                    check("write_owner", 32'(owner_id), 32'(e[IDW+W-1:W]));
                    check("write_ack", 32'(ack), 32'(oh));
                end
            end else begin
                check("idle_outputs", 32'({ack, w_data}), 32'd0);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: got no finish, expected finish by %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        req      = '0;
        req_data = '0;
        full     = 1'b0;
        rst_w_n  = 1'b0;

        // 1: single producer, two full bursts with one bubble between.
        do_reset();
        for (int j = 0; j < 8; j++) begin
            pq[0].push_back(W'(8'h10 + j));
            push_exp(0, 8'h10 + j);
        end
        drive();
        #1;
        tick();
        check("t1_grant_busy", 32'(busy), 32'd1);
        check("t1_grant_owner", 32'(owner_id), 32'd0);
        repeat (4) tick();
        check("t1_release_busy", 32'(busy), 32'd0);
        check("t1_release_burst", 32'(burst_cnt), 32'd4);
        check("t1_release_wrcount", 32'(wr_count), 32'd4);
        tick();
        check("t1_regrant_busy", 32'(busy), 32'd1);
        drain("t1", 100);
        check("t1_total", 32'(wr_count), 32'd8);

        // 2: all four requesting, round-robin 0,1,2,3,0,1,2,3.
        do_reset();
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 8; j++) pq[k].push_back(W'(k * 16 + j));
        for (int g = 0; g < 2; g++)
            for (int k = 0; k < 4; k++)
                for (int j = 0; j < 4; j++) push_exp(k, k * 16 + g * 4 + j);
        busy_cnt = 0;
        idle_cnt = 0;
        counting = 1'b1;
        drive();
        #1;
        drain("t2", 200);
        counting = 1'b0;
        check("t2_busy_cycles", 32'(busy_cnt), 32'd32);
        check("t2_idle_bubbles", 32'(idle_cnt), 32'd8);

        // 3: early release after two words, then next grant starts after owner 2.
        pq[2].push_back(8'h20);
        pq[2].push_back(8'h21);
        push_exp(2, 8'h20);
        push_exp(2, 8'h21);
        drive();
        #1;
        repeat (4) tick();
        check("t3_release_busy", 32'(busy), 32'd0);
        check("t3_release_burst", 32'(burst_cnt), 32'd2);
        check("t3_release_owner", 32'(owner_id), 32'd2);
        pq[0].push_back(8'h30);
        pq[1].push_back(8'h31);
        pq[3].push_back(8'h40);
        push_exp(3, 8'h40);
        push_exp(0, 8'h30);
        push_exp(1, 8'h31);
        drive();
        #1;
        drain("t3", 100);

        // 4: 16-deep FIFO model never read; then one read allows exactly one write.
        do_reset();
        fifo_on = 1'b1;
        occ     = 0;
        for (int j = 0; j < 12; j++) begin
            pq[0].push_back(W'(8'h50 + j));
            pq[1].push_back(W'(8'h60 + j));
        end
        for (int j = 0; j < 4; j++) push_exp(0, 8'h50 + j);
        for (int j = 0; j < 4; j++) push_exp(1, 8'h60 + j);
        for (int j = 4; j < 8; j++) push_exp(0, 8'h50 + j);
        for (int j = 4; j < 8; j++) push_exp(1, 8'h60 + j);
        drive();
        #1;
        wait_exp("t4_fill", 100);
        repeat (6) tick();
        check("t4_full_busy", 32'(busy), 32'd1);
        check("t4_full_owner", 32'(owner_id), 32'd0);
        check("t4_full_wen", 32'(w_en), 32'd0);
        check("t4_full_ack", 32'(ack), 32'd0);
        check("t4_full_burst", 32'(burst_cnt), 32'd0);
        check("t4_full_wrcount", 32'(wr_count), 32'd16);
        occ  = occ - 1;
        full = 1'b0;
        push_exp(0, 8'h58);
        repeat (5) tick();
        check("t4_one_more_wrcount", 32'(wr_count), 32'd17);
        check("t6_wrap_wrcount", 32'(wr_count_w), 32'd1);
        check("t4_one_more_burst", 32'(burst_cnt), 32'd1);
        check("t4_refull_wen", 32'(w_en), 32'd0);
        fifo_on = 1'b0;
        full    = 1'b0;
        for (int j = 9; j < 12; j++) push_exp(0, 8'h50 + j);
        for (int j = 8; j < 12; j++) push_exp(1, 8'h60 + j);
        drain("t4_rest", 100);
        check("t4_total", 32'(wr_count), 32'd24);
        check("t6_total_w", 32'(wr_count_w), 32'd8);

        // 5: reset mid-burst of owner 1; grant returns to owner 1 afterwards.
        do_reset();
        for (int j = 0; j < 8; j++) pq[1].push_back(W'(8'h70 + j));
        push_exp(1, 8'h70);
        push_exp(1, 8'h71);
        drive();
        #1;
        repeat (3) tick();
        check("t5_mid_burst", 32'(burst_cnt), 32'd2);
        check("t5_mid_owner", 32'(owner_id), 32'd1);
        rst_w_n = 1'b0;
        full    = 1'b1;
        tick();
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_ack", 32'(ack), 32'd0);
        check("t5_rst_wen", 32'(w_en), 32'd0);
        check("t5_rst_wrcount", 32'(wr_count), 32'd0);
        check("t5_rst_burst", 32'(burst_cnt), 32'd0);
        rst_w_n = 1'b1;
        full    = 1'b0;
        for (int j = 2; j < 8; j++) push_exp(1, 8'h70 + j);
        tick();
        check("t5_regrant_busy", 32'(busy), 32'd1);
        check("t5_regrant_owner", 32'(owner_id), 32'd1);
        drain("t5", 100);
        check("t5_total", 32'(wr_count), 32'd6);

        check("final_scoreboard", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write-port arbiter that shares one async_fifo write port among N producers in the w_clk domain. Each producer raises a request with its data word. The arbiter grants the port to one producer for a bounded burst and drives the FIFO's w_en/w_data. It never issues a write while the FIFO reports full.

Parameters:
N, 4, number of requesting producers (2..16)
WIDTH, 8, data word width; matches the FIFO width parameter
MAX_BURST, 4, maximum words accepted per grant before forced release (1..255)
CNT_W, 16, width of the wrap-around total-write counter

Ports:
w_clk  input  1  write-domain clock; all logic on posedge
rst_w_n  input  1  synchronous active-low reset, sampled on posedge w_clk
req  input  N  per-producer request; bit i held high while producer i has a word on req_data
req_data  input  N*WIDTH  packed producer words; producer i occupies bits [i*WIDTH +: WIDTH]
ack  output  N  one-hot accept; a word is consumed on any posedge where ack[i]=1
full  input  1  FIFO full flag, already in the w_clk domain
w_en  output  1  FIFO write enable
w_data  output  WIDTH  FIFO write data
busy  output  1  high while in GRANT state
owner_id  output  $clog2(N)  index of the current/last grant holder
burst_cnt  output  8  words accepted in the current grant
wr_count  output  CNT_W  total words written since reset; wraps modulo 2^CNT_W

Behaviour:
- Reset (rst_w_n=0 at posedge) takes effect regardless of state:
  - state=IDLE; owner_id=0; last_owner=N-1, so req[0] wins the first arbitration.
  - burst_cnt=0; wr_count=0; busy=0.
  - ack=0, w_en=0 and w_data=0 combinationally, because they derive from state=IDLE.
  - Any grant in progress is dropped and no partial burst is resumed.
- FSM states: IDLE, GRANT.
- IDLE:
  - If |req, select the first set req bit scanning from last_owner+1 upward, wrapping modulo N.
  - Load owner_id with that index, clear burst_cnt, go to GRANT. This is one cycle of arbitration latency.
  - If no req is set, stay in IDLE.
- GRANT, accept condition: accept = req[owner_id] & ~full.
  - ack[owner_id] = accept; all other ack bits are 0.
  - w_en = accept; w_data = req_data slice of owner_id. Both are combinational from registered owner_id.
  - When w_en=0, w_data is forced to 0.
- GRANT, on each accepting posedge: burst_cnt+1 and wr_count+1.
- GRANT, release to IDLE on the posedge where either:
  - (a) accept and burst_cnt == MAX_BURST-1, i.e. the MAX_BURST-th word is taken; or
  - (b) req[owner_id] = 0.
  - On release: last_owner = owner_id. burst_cnt holds its final value until the next grant loads.
  - Every release is followed by one IDLE bubble cycle.
- full during GRANT:
  - Grant is held, no ack, no w_en, burst_cnt frozen.
  - Owner keeps the port until full clears or it drops req. There is no stall timeout.
- Producer contract: req_data must be stable while req is high and ack is low. Producers must not drop req mid-word. Dropping req after an ack is a legal early release.
- Fairness: after owner k releases, the next arbitration starts at k+1. With all N requesting continuously, each producer is served once per N grants.
- wr_count wraps from 2^CNT_W-1 to 0 with no flag.
- Simultaneous full rising on the same posedge as the last burst word: that word is not accepted (full gates accept). Release happens later via (a) or (b).

Test Plan:
1. Reset, then req=4'b0001, producer 0 supplies 0x10..0x13, full=0 → grant 1 cycle after req; w_en high for 4 consecutive cycles with w_data 0x10,0x11,0x12,0x13; release; busy=0 for 1 cycle; regrant to 0 for the next words; wr_count=4 after the first burst.
2. req=4'b1111 held, MAX_BURST=4, full=0 → grant order 0,1,2,3,0; each grant exactly 4 writes; exactly one idle bubble between grants; owner_id sequence matches.
3. Producer 2 alone writes 2 words then drops req → release after 2 writes with burst_cnt=2; next grant goes to the lowest requester ≥3 (wrapping).
4. Connect the real async_fifo (DEPTH=16) and never read; req=4'b0011 → exactly 16 writes accepted, then full=1; no ack or w_en while full. Read one word in r_clk domain → after full deasserts, exactly one more write is accepted.
5. Assert rst_w_n=0 for 1 cycle mid-burst (burst_cnt=2, owner 1) → next cycle state IDLE, ack=0, w_en=0, wr_count=0; with req=4'b0010 still high, grant goes to owner 1 again (reset priority starts at 0, so any req[0] wins first).
6. CNT_W=4 build, 17 accepted writes → wr_count reads 1.
